// File: rtl/riscv_pkg.sv
// Shared core package: register-file sizing and scoreboard types.
// Imported by the register file, its interface and the testbench.
package riscv_pkg;

    localparam int REGISTER_PORTS      = 2;
    localparam int REGISTER_LOCK_CNT_W = 2;
    localparam int LOCK_CNT_W          = REGISTER_LOCK_CNT_W;

    typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;

endpackage

// File: rtl/riscv_regfile_if.sv
// Lock and write port bundle between the execute stage and the register file.
// The execute stage is the master; the register file is the slave.
interface riscv_regfile_if
    import riscv_pkg::*;
#(
    parameter int PORTS = REGISTER_PORTS
);

    logic [PORTS-1:0]             register_lock_en;
    logic [PORTS-1:0][4:0]        register_lock;
    logic [PORTS-1:0]             register_write_en;
    logic [PORTS-1:0][4:0]        register_write;
    logic [PORTS-1:0][31:0]       register_write_data;

    modport master (
        output register_lock_en,
        output register_lock,
        output register_write_en,
        output register_write,
        output register_write_data
    );

    modport slave (
        input register_lock_en,
        input register_lock,
        input register_write_en,
        input register_write,
        input register_write_data
    );

endinterface

// File: rtl/riscv_regfile_scoreboard.sv
// Outstanding-writer counters for x1..x31, locked decode and error pulse.
// Counters saturate on overflow and hold at zero on underflow.
module riscv_regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int PORTS      = REGISTER_PORTS,
    parameter int LOCK_CNT_W = REGISTER_LOCK_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PORTS-1:0]       lock_en,
    input  logic [PORTS-1:0][4:0]  lock_idx,
    input  logic [PORTS-1:0]       write_en,
    input  logic [PORTS-1:0][4:0]  write_idx,
    output logic [31:0]            locked,
    output logic                   err
);

    localparam int CNT_MAX = (1 << LOCK_CNT_W) - 1;

    logic [31:1][LOCK_CNT_W-1:0] cnt_q;
    logic [31:1][LOCK_CNT_W-1:0] cnt_d;
    logic                        err_q;
    logic                        err_d;
    int                          n_lock;
    int                          n_write;
    int                          sum;

    function automatic int hits(
        input logic [PORTS-1:0]      en,
        input logic [PORTS-1:0][4:0] idx,
        input int                    r
    );
        int n;
        n = 0;
        for (int p = 0; p < PORTS; p++) begin
            if (en[p] && (idx[p] == 5'(r))) begin
                n = n + 1;
            end
        end
        return n;
    endfunction

    // Next counter values and violation detection for every register.
    always_comb begin
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        n_lock  = 0;
        n_write = 0;
        sum     = 0;
        for (int i = 1; i < 32; i++) begin
            n_lock  = hits(lock_en, lock_idx, i);
            n_write = hits(write_en, write_idx, i);
            sum     = int'(cnt_q[i]) + n_lock - n_write;
            if (n_write > 1) begin
                err_d = 1'b1;
            end
            if (sum > CNT_MAX) begin
                cnt_d[i] = LOCK_CNT_W'(CNT_MAX);
                err_d    = 1'b1;
            end else if (sum < 0) begin
                cnt_d[i] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[i] = LOCK_CNT_W'(sum);
            end
        end
    end

    // Counter and error flops; reset overrides any traffic that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Locked flags decoded straight from the counter flops.
    always_comb begin
        locked = '0;
        for (int i = 1; i < 32; i++) begin
            locked[i] = (cnt_q[i] != '0);
        end
    end

    assign err = err_q;

endmodule

// File: rtl/riscv_regfile.sv
// RV32 integer register file with per-register write scoreboard.
// x0 reads as zero; the highest port index wins on colliding writes.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int PORTS      = REGISTER_PORTS,
    parameter int LOCK_CNT_W = REGISTER_LOCK_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    riscv_regfile_if.slave      bus,
    output logic [31:0][31:0]   register,
    output logic [31:0]         register_locked,
    output logic                scoreboard_err
);

    logic [31:1][31:0] regs_q;
    logic [31:1][31:0] regs_d;

    // Write-port mux: later ports override earlier ones.
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (bus.register_write_en[p] &&
                    (bus.register_write[p] == 5'(i))) begin
                    regs_d[i] = bus.register_write_data[p];
                end
            end
        end
    end

    // Architectural state for x1..x31.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign register = {regs_q, 32'h0};

    riscv_regfile_scoreboard #(
        .PORTS      (PORTS),
        .LOCK_CNT_W (LOCK_CNT_W)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .lock_en   (bus.register_lock_en),
        .lock_idx  (bus.register_lock),
        .write_en  (bus.register_write_en),
        .write_idx (bus.register_write),
        .locked    (register_locked),
        .err       (scoreboard_err)
    );

endmodule

// File: tb/tb_riscv_regfile.sv
// Directed testbench for riscv_regfile with two ports and 2-bit counters.
// Each step drives inputs, clocks once, then checks outputs 1ns later.
module tb_riscv_regfile;

    import riscv_pkg::*;

    logic              clock;
    logic              reset;
    logic [31:0][31:0] register;
    logic [31:0]       register_locked;
    logic              scoreboard_err;

    int n_tests;
    int n_fail;

    riscv_regfile_if #(.PORTS(2)) bus ();

    riscv_regfile #(
        .PORTS      (2),
        .LOCK_CNT_W (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus),
        .register        (register),
        .register_locked (register_locked),
        .scoreboard_err  (scoreboard_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.register_lock_en    = '0;
        bus.register_lock       = '0;
        bus.register_write_en   = '0;
        bus.register_write      = '0;
        bus.register_write_data = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic lock(input int p, input logic [4:0] r);
        bus.register_lock_en[p] = 1'b1;
        bus.register_lock[p]    = r;
    endtask

    task automatic wr(input int p, input logic [4:0] r,
                      input logic [31:0] d);
        bus.register_write_en[p]   = 1'b1;
        bus.register_write[p]      = r;
        bus.register_write_data[p] = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();

        for (int i = 0; i < 32; i++) begin
            check($sformatf("reset_reg%0d", i), register[i], 32'h0);
        end
        check("reset_locked", register_locked, 32'h0);
        check("reset_err", 32'(scoreboard_err), 32'h0);

        lock(0, 5'd5);
        tick();
        idle_inputs();
        check("x5_locked_after_lock", 32'(register_locked[5]), 32'h1);
        check("x5_lock_err", 32'(scoreboard_err), 32'h0);
        tick();
        check("x5_still_locked", 32'(register_locked[5]), 32'h1);
        check("x5_no_early_data", register[5], 32'h0);
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle_inputs();
        check("x5_unlocked", 32'(register_locked[5]), 32'h0);
        check("x5_data", register[5], 32'hDEADBEEF);
        check("x5_write_err", 32'(scoreboard_err), 32'h0);

        lock(0, 5'd0);
        wr(1, 5'd0, 32'h1234);
        tick();
        idle_inputs();
        check("x0_data", register[0], 32'h0);
        check("x0_locked", 32'(register_locked[0]), 32'h0);
        check("x0_err", 32'(scoreboard_err), 32'h0);

        for (int k = 0; k < 3; k++) begin
            lock(0, 5'd7);
            tick();
            idle_inputs();
            check($sformatf("x7_lock%0d_err", k), 32'(scoreboard_err), 32'h0);
        end
        lock(0, 5'd7);
        tick();
        idle_inputs();
        check("x7_overflow_err", 32'(scoreboard_err), 32'h1);
        tick();
        check("x7_err_one_cycle", 32'(scoreboard_err), 32'h0);
        for (int k = 0; k < 2; k++) begin
            wr(0, 5'd7, 32'(k + 1));
            tick();
            idle_inputs();
            check($sformatf("x7_locked_w%0d", k), 32'(register_locked[7]), 32'h1);
            check($sformatf("x7_err_w%0d", k), 32'(scoreboard_err), 32'h0);
        end
        wr(0, 5'd7, 32'h77);
        tick();
        idle_inputs();
        check("x7_unlocked", 32'(register_locked[7]), 32'h0);
        check("x7_data", register[7], 32'h77);
        check("x7_last_err", 32'(scoreboard_err), 32'h0);

        wr(0, 5'd9, 32'h55);
        tick();
        idle_inputs();
        check("x9_data", register[9], 32'h55);
        check("x9_underflow_err", 32'(scoreboard_err), 32'h1);
        check("x9_locked", 32'(register_locked[9]), 32'h0);
        tick();
        check("x9_err_clears", 32'(scoreboard_err), 32'h0);

        wr(0, 5'd10, 32'h1);
        wr(1, 5'd10, 32'h2);
        tick();
        idle_inputs();
        check("x10_port1_wins", register[10], 32'h2);
        check("x10_collision_err", 32'(scoreboard_err), 32'h1);
        tick();
        check("x10_err_clears", 32'(scoreboard_err), 32'h0);

        lock(0, 5'd3);
        tick();
        idle_inputs();
        check("x3_locked", 32'(register_locked[3]), 32'h1);
        lock(0, 5'd3);
        wr(1, 5'd3, 32'h33);
        tick();
        idle_inputs();
        check("x3_same_cycle_locked", 32'(register_locked[3]), 32'h1);
        check("x3_same_cycle_data", register[3], 32'h33);
        check("x3_same_cycle_err", 32'(scoreboard_err), 32'h0);
        wr(0, 5'd3, 32'h34);
        tick();
        idle_inputs();
        check("x3_count_was_one", 32'(register_locked[3]), 32'h0);
        check("x3_final_err", 32'(scoreboard_err), 32'h0);

        lock(0, 5'd12);
        tick();
        idle_inputs();
        check("x12_locked", 32'(register_locked[12]), 32'h1);
        reset = 1'b1;
        wr(0, 5'd4, 32'hABCD);
        lock(1, 5'd6);
        tick();
        reset = 1'b0;
        idle_inputs();
        check("rst_x4", register[4], 32'h0);
        check("rst_x5", register[5], 32'h0);
        check("rst_x9", register[9], 32'h0);
        check("rst_locked", register_locked, 32'h0);
        check("rst_err", 32'(scoreboard_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_regfile.md
# riscv_regfile

Architectural integer register file and write scoreboard for the RV32 core. It is the receiving end of the execute unit's register lock and write ports. It holds x0–x31 and tracks outstanding writers per register, so the execute stage can read operands and see which registers are still pending. The full register array and a per-register locked vector are presented every cycle.

## Interface
Parameters:
- `PORTS`, default `riscv_pkg::REGISTER_PORTS`: number of lock/write port pairs.
- `LOCK_CNT_W`, default `riscv_pkg::REGISTER_LOCK_CNT_W` (2): width of each per-register outstanding-writer counter.

Ports:
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `register_lock_en`, input, [PORTS-1:0]: lock request per port.
- `register_lock`, input, [PORTS-1:0][4:0]: register index to lock.
- `register_write_en`, input, [PORTS-1:0]: write (and unlock) per port.
- `register_write`, input, [PORTS-1:0][4:0]: register index to write.
- `register_write_data`, input, [PORTS-1:0][31:0]: write data.
- `register`, output, [31:0][31:0]: current architectural values; entry 0 is always 0.
- `register_locked`, output, [31:0]: 1 while a register has at least one outstanding writer; bit 0 is always 0.
- `scoreboard_err`, output, 1: one-cycle pulse on any scoreboard violation.

## Operation
- Storage: 31 × 32-bit flops for x1–x31. x0 is constant 0. Locks and writes targeting x0 are ignored and never raise an error.
- Write: if `register_write_en[p]` is set, `register[register_write[p]]` takes `register_write_data[p]` at the next edge. There is no same-cycle bypass.
- Multiple ports writing the same register in one cycle: the highest port index wins the data, and `scoreboard_err` pulses.
- Scoreboard: each register x1–x31 has a LOCK_CNT_W-bit counter.
  - Next value = cnt + (number of ports locking i) − (number of ports writing i).
  - `register_locked[i]` = (cnt[i] != 0), decoded directly from the counter flops.
- Lock and write to the same register in the same cycle: the net change is 0. The data is still written.
- Overflow: if the result would exceed 2^LOCK_CNT_W − 1, the counter saturates at the maximum and `scoreboard_err` pulses.
- Underflow: if the result would go below 0 (a write with no outstanding lock), the counter stays at 0. The write is still performed and `scoreboard_err` pulses.
- `scoreboard_err` is registered: it asserts on the cycle after the offending inputs, for exactly one cycle per offending cycle.

## Timing
- Reset values:
  - all `register` entries = 0;
  - all counters = 0, so `register_locked` = 0;
  - `scoreboard_err` = 0.
- Reset asserted mid-operation: the reset wins over any lock or write presented in the same cycle. Every counter and data register clears at that edge.
- Write latency: 1 cycle. Data presented at edge N is visible on `register` after edge N.
- Lock latency: 1 cycle. `register_locked` rises after the edge at which the lock is sampled. The issuing stage must therefore hold off dependents itself for that cycle.
- Unlock latency: 1 cycle. `register_locked` falls after the edge of the final write, in the same cycle the new data becomes visible.
- No handshake and no backpressure: every lock and write is accepted in the cycle it is presented.

## Structure
- `riscv_pkg` additions:
  - `REGISTER_LOCK_CNT_W` (= 2);
  - `typedef logic [LOCK_CNT_W-1:0] lock_cnt_t`.
- `REGISTER_PORTS` is already present in the package.
- Sub-module `riscv_regfile_scoreboard` holds the 31 counters, the locked decode and the error generation. The top level holds the data array and the write-port priority mux.

## Test plan
- Reset, then 3 idle cycles → all `register` = 0, `register_locked` = 0, `scoreboard_err` = 0.
- Lock x5 at cycle 1; write x5 = 0xDEADBEEF at cycle 3 → `register_locked[5]` = 1 after cycle 1 and 0 after cycle 3. `register[5]` = 0xDEADBEEF after cycle 3. No error.
- Lock x0 and write x0 = 0x1234 → `register[0]` stays 0, `register_locked[0]` stays 0, no error.
- Lock x7 four times (LOCK_CNT_W = 2): count reaches 3 and saturates on the fourth lock → `scoreboard_err` pulses once. Three writes then clear `register_locked[7]`.
- Write x9 = 0x55 with no lock → `register[9]` = 0x55, count stays 0, `scoreboard_err` pulses one cycle later. With PORTS ≥ 2, both ports write x10 (0x1 on port 0, 0x2 on port 1) → `register[10]` = 0x2 and an error pulse.
- Lock and write x3 in the same cycle with x3 count at 1 → count stays 1, data updates. Then assert `reset` in the same cycle as a write to x4 → all registers and counters are 0 after that edge.
